// File: rtl/list_packer.sv
// Packs DW-wide list elements into DBW-wide AXI4-Stream beats, with TLAST/TKEEP on list end.
// Optional element/list counters are enabled with the LIST_PACKER_COUNT_EN macro.
//
//   state  | meaning
//   S_FILL | assembling a beat; elements accepted
//   S_PEND | completed beat held in assembly, waiting for the output register
module list_packer #(
  parameter int DW  = 32,
  parameter int DBW = 256
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [DW-1:0]    I_DATA,
  input  logic             I_VALID,
  input  logic             I_LAST,
  output logic             O_READY,
  output logic [DBW-1:0]   M0_AXIS_TDATA,
  output logic [DBW/8-1:0] M0_AXIS_TKEEP,
  output logic             M0_AXIS_TVALID,
  input  logic             M0_AXIS_TREADY,
  output logic             M0_AXIS_TLAST
`ifdef LIST_PACKER_COUNT_EN
  ,
  output logic [31:0]      O_COUNT,
  output logic [15:0]      O_LISTS
`endif
);

  localparam int FS  = DBW / DW;
  localparam int LW  = $clog2(FS);
  localparam int KPL = DW / 8;
  localparam int KW  = DBW / 8;

  typedef enum logic {S_FILL, S_PEND} state_t;

  state_t         state_q, state_d;
  logic [LW-1:0]  lane_q;
  logic [DBW-1:0] asm_data_q;
  logic [KW-1:0]  asm_keep_q;
  logic           asm_last_q;

  logic           acc, out_free, complete;
  logic [DBW-1:0] beat_data;
  logic [KW-1:0]  beat_keep;
  logic           load_out, out_from_asm, asm_clr, asm_upd;

  assign O_READY  = (state_q == S_FILL);
  assign acc      = I_VALID & O_READY;
  assign out_free = ~M0_AXIS_TVALID | M0_AXIS_TREADY;
  assign complete = acc & ((&lane_q) | I_LAST);

  // Assembly contents with the incoming element merged into its lane
  always_comb begin
    beat_data = asm_data_q;
    beat_keep = asm_keep_q;
    beat_data[lane_q*DW +: DW]   = I_DATA;
    beat_keep[lane_q*KPL +: KPL] = '1;
  end

  always_comb begin
    state_d      = state_q;
    load_out     = 1'b0;
    out_from_asm = 1'b0;
    asm_clr      = 1'b0;
    asm_upd      = 1'b0;
    case (state_q)
      S_FILL: begin
        if (complete && out_free) begin
          load_out = 1'b1;
          asm_clr  = 1'b1;
        end else if (complete) begin
          asm_upd = 1'b1;
          state_d = S_PEND;
        end else if (acc) begin
          asm_upd = 1'b1;
        end
      end
      S_PEND: begin
        if (out_free) begin
          load_out     = 1'b1;
          out_from_asm = 1'b1;
          asm_clr      = 1'b1;
          state_d      = S_FILL;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q    <= S_FILL;
      lane_q     <= '0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      asm_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (asm_clr) begin
        lane_q     <= '0;
        asm_data_q <= '0;
        asm_keep_q <= '0;
        asm_last_q <= 1'b0;
      end else if (asm_upd) begin
        lane_q     <= lane_q + 1'b1;
        asm_data_q <= beat_data;
        asm_keep_q <= beat_keep;
        asm_last_q <= I_LAST;
      end
    end
  end

  // Output register only changes when empty or being handshaken, so it holds under backpressure
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      M0_AXIS_TDATA  <= '0;
      M0_AXIS_TKEEP  <= '0;
      M0_AXIS_TLAST  <= 1'b0;
      M0_AXIS_TVALID <= 1'b0;
    end else if (load_out) begin
      M0_AXIS_TDATA  <= out_from_asm ? asm_data_q : beat_data;
      M0_AXIS_TKEEP  <= out_from_asm ? asm_keep_q : beat_keep;
      M0_AXIS_TLAST  <= out_from_asm ? asm_last_q : I_LAST;
      M0_AXIS_TVALID <= 1'b1;
    end else if (M0_AXIS_TREADY) begin
      M0_AXIS_TVALID <= 1'b0;
    end
  end

`ifdef LIST_PACKER_COUNT_EN
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      O_COUNT <= '0;
      O_LISTS <= '0;
    end else begin
      if (acc) O_COUNT <= O_COUNT + 32'd1;
      if (M0_AXIS_TVALID && M0_AXIS_TREADY && M0_AXIS_TLAST) O_LISTS <= O_LISTS + 16'd1;
    end
  end
`endif

endmodule
